// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result bit per cycle.
// A conversion takes WIDTH shift cycles plus one DONE cycle; results are held until the next DONE.
module binary_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic [BCD_W-1:0]   scr_adj;
  logic               ovf_s_q, ovf_s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  // Add-3 correction: every scratch digit >= 5 is bumped before the shift
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    ovf_s_d = ovf_s_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = binary_in;
          scr_d   = '0;
          ovf_s_d = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The bit leaving the top digit represents 10^DIGITS: it is dropped and remembered
        scr_d   = {scr_adj[BCD_W-2:0], sr_q[WIDTH-1]};
        sr_d    = sr_q << 1;
        ovf_s_d = ovf_s_q | scr_adj[BCD_W-1];
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Results are loaded on entry to DONE so they appear together with valid
          state_d = S_DONE;
          bcd_d   = scr_d;
          ovf_d   = ovf_s_d;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      ovf_s_q <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      ovf_s_q <= ovf_s_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule
